// File: rtl/ldpc_ber_run_ctrl_if.sv
// rtl/ldpc_ber_run_ctrl_if.sv - command, config, datapath and status bundle for the BER run sequencer
interface ldpc_ber_run_ctrl_if #(
  parameter int CYCLE_CNT_WIDTH = 48
);
  logic                       cmd_start;
  logic                       cmd_abort;
  logic [63:0]                cfg_max_blocks;
  logic [31:0]                cfg_max_errors;
  logic [15:0]                cfg_drain_cycles;
  logic                       ctrl_en;
  logic                       ctrl_sw_resetn;
  logic [63:0]                data_finished_blocks;
  logic [31:0]                data_bit_errors;
  logic                       status_busy;
  logic                       status_done;
  logic [1:0]                 status_reason;
  logic [CYCLE_CNT_WIDTH-1:0] status_cycles;

  // Regmap / datapath side
  modport master (
    output cmd_start, cmd_abort, cfg_max_blocks, cfg_max_errors, cfg_drain_cycles,
    output data_finished_blocks, data_bit_errors,
    input  ctrl_en, ctrl_sw_resetn, status_busy, status_done, status_reason, status_cycles
  );

  // Sequencer side
  modport slave (
    input  cmd_start, cmd_abort, cfg_max_blocks, cfg_max_errors, cfg_drain_cycles,
    input  data_finished_blocks, data_bit_errors,
    output ctrl_en, ctrl_sw_resetn, status_busy, status_done, status_reason, status_cycles
  );
endinterface

// File: rtl/ldpc_ber_run_ctrl.sv
// rtl/ldpc_ber_run_ctrl.sv - LDPC BER measurement run sequencer (reset, run, drain, done)
module ldpc_ber_run_ctrl #(
  parameter int RESET_CYCLES    = 16,
  parameter int CYCLE_CNT_WIDTH = 48
) (
  input  logic                  data_clk,
  input  logic                  data_resetn,
  ldpc_ber_run_ctrl_if.slave    bus
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES - 1);

  localparam logic [1:0] REASON_NONE  = 2'd0;
  localparam logic [1:0] REASON_BLOCK = 2'd1;
  localparam logic [1:0] REASON_ERROR = 2'd2;
  localparam logic [1:0] REASON_ABORT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [RW-1:0]              rst_cnt_q, rst_cnt_d;
  logic [15:0]                drain_cnt_q, drain_cnt_d;
  logic [1:0]                 reason_q, reason_d;
  logic [CYCLE_CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic                       load_cfg;

  logic [63:0]                max_blocks_q;
  logic [31:0]                max_errors_q;
  logic [15:0]                drain_cfg_q;

  logic                       hit_blk_q, hit_blk_d;
  logic                       hit_err_q, hit_err_d;

  logic                       en_q, sw_resetn_q, busy_q, done_q;

  // Limit compares are registered so the wide compare is off the FSM path;
  // they are only armed while running so stale counts never leak into a run.
  always_comb begin
    hit_blk_d = (state_q == ST_RUN) && (max_blocks_q != 64'd0) &&
                (bus.data_finished_blocks >= max_blocks_q);
    hit_err_d = (state_q == ST_RUN) && (max_errors_q != 32'd0) &&
                (bus.data_bit_errors >= max_errors_q);
  end

  // Next-state, counter and status decode
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    drain_cnt_d = drain_cnt_q;
    reason_d    = reason_q;
    cycles_d    = cycles_q;
    load_cfg    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A simultaneous abort cancels the start and leaves status untouched
        if (bus.cmd_start && !bus.cmd_abort) begin
          state_d   = ST_RESET;
          rst_cnt_d = RST_LOAD;
          reason_d  = REASON_NONE;
          cycles_d  = '0;
          load_cfg  = 1'b1;
        end
      end

      ST_RESET: begin
        if (bus.cmd_abort) begin
          state_d  = ST_DONE;
          reason_d = REASON_ABORT;
        end else if (rst_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end

      ST_RUN: begin
        if (!(&cycles_q)) begin
          cycles_d = cycles_q + 1'b1;
        end
        if (bus.cmd_abort || hit_err_q || hit_blk_q) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = drain_cfg_q;
          if (bus.cmd_abort) begin
            reason_d = REASON_ABORT;
          end else if (hit_err_q) begin
            reason_d = REASON_ERROR;
          end else begin
            reason_d = REASON_BLOCK;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q == 16'd0) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state so
  // they change on the same edge as the transition
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      drain_cnt_q  <= 16'd0;
      reason_q     <= REASON_NONE;
      cycles_q     <= '0;
      hit_blk_q    <= 1'b0;
      hit_err_q    <= 1'b0;
      en_q         <= 1'b0;
      sw_resetn_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      reason_q     <= reason_d;
      cycles_q     <= cycles_d;
      hit_blk_q    <= hit_blk_d;
      hit_err_q    <= hit_err_d;
      en_q         <= (state_d == ST_RUN);
      sw_resetn_q  <= (state_d != ST_RESET);
      busy_q       <= (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q       <= (state_d == ST_DONE);
    end
  end

  // Run configuration snapshot taken when a start is accepted
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      max_blocks_q <= 64'd0;
      max_errors_q <= 32'd0;
      drain_cfg_q  <= 16'd0;
    end else if (load_cfg) begin
      max_blocks_q <= bus.cfg_max_blocks;
      max_errors_q <= bus.cfg_max_errors;
      drain_cfg_q  <= bus.cfg_drain_cycles;
    end
  end

  assign bus.ctrl_en        = en_q;
  assign bus.ctrl_sw_resetn = sw_resetn_q;
  assign bus.status_busy    = busy_q;
  assign bus.status_done    = done_q;
  assign bus.status_reason  = reason_q;
  assign bus.status_cycles  = cycles_q;

endmodule

// File: tb/tb_ldpc_ber_run_ctrl.sv
// tb/tb_ldpc_ber_run_ctrl.sv - self-checking bench for the BER run sequencer
module tb_ldpc_ber_run_ctrl;

  localparam int RESET_CYCLES = 16;
  localparam int CW           = 48;

  logic data_clk;
  logic data_resetn;

  ldpc_ber_run_ctrl_if #(.CYCLE_CNT_WIDTH(CW)) dif ();

  ldpc_ber_run_ctrl #(
    .RESET_CYCLES   (RESET_CYCLES),
    .CYCLE_CNT_WIDTH(CW)
  ) dut (
    .data_clk    (data_clk),
    .data_resetn (data_resetn),
    .bus         (dif.master)
  );

  initial data_clk = 1'b0;
  always #5 data_clk = ~data_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Datapath emulation rates (per enabled cycle)
  int binc_g = 1;
  int einc_g = 0;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: datapath counters advance on cycles where enable was high,
  // clear while sw reset is low; command pulses last a single cycle.
  task automatic step();
    logic en_prev;
    en_prev = dif.ctrl_en;
    @(posedge data_clk);
    #1;
    dif.cmd_start = 1'b0;
    dif.cmd_abort = 1'b0;
    if (!dif.ctrl_sw_resetn) begin
      dif.data_finished_blocks = 64'd0;
      dif.data_bit_errors      = 32'd0;
    end else if (en_prev) begin
      dif.data_finished_blocks = dif.data_finished_blocks + 64'(binc_g);
      dif.data_bit_errors      = dif.data_bit_errors + 32'(einc_g);
    end
  endtask

  // Runs one measurement and checks phase lengths and final status against
  // values computed from the limits and the datapath count rates.
  task automatic run(input string tag, input longint unsigned mb, input int unsigned me,
                     input int unsigned dr, input int binc, input int einc,
                     input int abort_run, input int abort_rst, input bit disturb);
    int rst_low, en_cnt, drn, steps;
    bit saw_en, fin;
    longint jb, je, j;
    longint exp_en;
    int exp_reason;
    rst_low = 0; en_cnt = 0; drn = 0; steps = 0; saw_en = 0; fin = 0;
    binc_g = binc;
    einc_g = einc;
    dif.cfg_max_blocks   = mb;
    dif.cfg_max_errors   = me;
    dif.cfg_drain_cycles = 16'(dr);
    dif.cmd_start = 1'b1;
    step();
    chk({tag, "_start_busy"}, dif.status_busy, 1);
    chk({tag, "_start_done"}, dif.status_done, 0);
    chk({tag, "_start_reason"}, dif.status_reason, 0);
    chk({tag, "_start_cycles"}, dif.status_cycles, 0);
    if (disturb) begin
      dif.cfg_max_blocks   = 64'd1;
      dif.cfg_max_errors   = 32'd1;
      dif.cfg_drain_cycles = 16'd0;
    end
    while (!fin && steps < 5000) begin
      if (!dif.ctrl_sw_resetn) rst_low++;
      if (dif.ctrl_en) begin
        en_cnt++;
        saw_en = 1'b1;
      end
      if (dif.status_busy && !dif.ctrl_en && dif.ctrl_sw_resetn && saw_en) drn++;
      if (abort_rst > 0 && !dif.ctrl_sw_resetn && rst_low == abort_rst) dif.cmd_abort = 1'b1;
      if (abort_run > 0 && dif.ctrl_en && en_cnt == abort_run) dif.cmd_abort = 1'b1;
      if (disturb && dif.ctrl_en && en_cnt == 5) dif.cmd_start = 1'b1;
      step();
      steps++;
      if (dif.status_done) fin = 1'b1;
    end
    chk({tag, "_timeout"}, fin, 1);
    chk({tag, "_end_busy"}, dif.status_busy, 0);
    chk({tag, "_end_en"}, dif.ctrl_en, 0);
    chk({tag, "_end_swrstn"}, dif.ctrl_sw_resetn, 1);
    if (abort_rst > 0) begin
      chk({tag, "_rst_low"}, rst_low, abort_rst);
      chk({tag, "_en_cycles"}, en_cnt, 0);
      chk({tag, "_reason"}, dif.status_reason, 3);
      chk({tag, "_cycles"}, dif.status_cycles, 0);
    end else begin
      if (abort_run > 0) begin
        exp_en     = abort_run;
        exp_reason = 3;
      end else begin
        jb = (mb != 0) ? longint'((mb + longint'(binc) - 1) / longint'(binc)) + 1 : 64'sh7fffffff;
        je = (me != 0 && einc > 0) ? longint'((me + einc - 1) / einc) + 1 : 64'sh7fffffff;
        j  = (jb < je) ? jb : je;
        exp_en     = j + 1;
        exp_reason = (je <= jb) ? 2 : 1;
      end
      chk({tag, "_rst_low"}, rst_low, RESET_CYCLES);
      chk({tag, "_en_cycles"}, en_cnt, exp_en);
      chk({tag, "_cycles"}, dif.status_cycles, exp_en);
      chk({tag, "_drain"}, drn, dr + 1);
      chk({tag, "_reason"}, dif.status_reason, exp_reason);
    end
  endtask

  initial begin
    int unsigned prev_reason;
    int steps;
    data_resetn              = 1'b1;
    dif.cmd_start            = 1'b0;
    dif.cmd_abort            = 1'b0;
    dif.cfg_max_blocks       = 64'd0;
    dif.cfg_max_errors       = 32'd0;
    dif.cfg_drain_cycles     = 16'd0;
    dif.data_finished_blocks = 64'd0;
    dif.data_bit_errors      = 32'd0;
    #2 data_resetn = 1'b0;
    @(posedge data_clk);
    @(posedge data_clk);
    #1;
    chk("rst_en", dif.ctrl_en, 0);
    chk("rst_swrstn", dif.ctrl_sw_resetn, 1);
    chk("rst_busy", dif.status_busy, 0);
    chk("rst_done", dif.status_done, 0);
    chk("rst_reason", dif.status_reason, 0);
    chk("rst_cycles", dif.status_cycles, 0);
    data_resetn = 1'b1;
    step();

    // start and abort together in IDLE: nothing happens
    dif.cmd_start = 1'b1;
    dif.cmd_abort = 1'b1;
    step();
    chk("idle_sa_busy", dif.status_busy, 0);
    chk("idle_sa_done", dif.status_done, 0);

    run("blk",    100,  0,  4, 1, 0, 0, 0, 0);
    run("err",    1000, 50, 3, 1, 2, 0, 0, 0);
    run("both",   100,  50, 2, 2, 1, 0, 0, 0);
    run("rstab",  100,  0,  4, 1, 0, 0, 5, 0);
    run("abort",  0,    0,  6, 1, 1, 1000, 0, 0);
    run("dist",   60,   0,  0, 1, 0, 0, 0, 1);

    // start and abort together in DONE: status held
    prev_reason = dif.status_reason;
    dif.cmd_start = 1'b1;
    dif.cmd_abort = 1'b1;
    step();
    chk("done_sa_done", dif.status_done, 1);
    chk("done_sa_busy", dif.status_busy, 0);
    chk("done_sa_reason", dif.status_reason, prev_reason);

    for (int i = 0; i < 6; i++) begin
      int unsigned mb, me, dr;
      int binc, einc;
      mb   = $urandom_range(150, 10);
      me   = ($urandom_range(1, 0) == 1) ? $urandom_range(120, 5) : 0;
      dr   = $urandom_range(7, 0);
      binc = int'($urandom_range(3, 1));
      einc = int'($urandom_range(3, 0));
      run($sformatf("rnd%0d", i), mb, me, dr, binc, einc, 0, 0, ($urandom_range(1, 0) == 1));
    end

    // async reset in the middle of DRAIN: outputs drop to reset values at once
    binc_g = 1;
    einc_g = 0;
    dif.cfg_max_blocks   = 64'd10;
    dif.cfg_max_errors   = 32'd0;
    dif.cfg_drain_cycles = 16'd20;
    dif.cmd_start = 1'b1;
    step();
    steps = 0;
    while (!(dif.ctrl_sw_resetn && !dif.ctrl_en && dif.status_busy && dif.status_cycles != 0) && steps < 200) begin
      step();
      steps++;
    end
    chk("ar_reach_drain", (steps < 200), 1);
    step();
    step();
    #2 data_resetn = 1'b0;
    #1;
    chk("ar_en", dif.ctrl_en, 0);
    chk("ar_swrstn", dif.ctrl_sw_resetn, 1);
    chk("ar_busy", dif.status_busy, 0);
    chk("ar_done", dif.status_done, 0);
    chk("ar_reason", dif.status_reason, 0);
    chk("ar_cycles", dif.status_cycles, 0);
    data_resetn = 1'b1;
    step();
    step();
    chk("ar_post_busy", dif.status_busy, 0);
    chk("ar_post_done", dif.status_done, 0);

    run("after_ar", 30, 0, 1, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
